// File: rtl/relu_act_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : relu_act_pipe                                                    |
// | Brief   : Two-stage multi-lane activation unit (ReLU / leaky / clipped /   |
// |           pass) with valid/ready flow control and a negative-lane counter. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module relu_act_pipe #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              in_mode,
    input  logic [DATA_W-1:0]       clip_max,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    stat_clr,
    output logic [CNT_W-1:0]        zero_cnt
);

    localparam int c_NEG_W = $clog2(LANES + 1);

    localparam logic [1:0] c_MODE_RELU  = 2'b00;
    localparam logic [1:0] c_MODE_LEAKY = 2'b01;
    localparam logic [1:0] c_MODE_CLIP  = 2'b10;
    localparam logic [1:0] c_MODE_PASS  = 2'b11;

    logic                      r_v1;
    logic [LANES*DATA_W-1:0]   r_s1_data;
    logic [1:0]                r_s1_mode;
    logic signed [DATA_W-1:0]  r_s1_clip;

    logic                      r_v2;
    logic [LANES*DATA_W-1:0]   r_s2_data;
    logic [c_NEG_W-1:0]        r_s2_neg;

    logic [CNT_W-1:0]          r_cnt;

    logic                      w_s2_take;
    logic                      w_in_ready;
    logic                      w_clip_pos;
    logic [LANES*DATA_W-1:0]   w_result;
    logic [LANES-1:0]          w_sign;
    logic [c_NEG_W-1:0]        w_neg;
    logic [CNT_W:0]            w_cnt_sum;
    logic [CNT_W-1:0]          w_cnt_next;

    assign w_s2_take  = !r_v2 || out_ready;
    assign w_in_ready = !r_v1 || w_s2_take;
    assign w_clip_pos = !r_s1_clip[DATA_W-1] && (|r_s1_clip);

    // Stage 1: capture the beat together with its mode and clip bound
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_s1_data <= '0;
            r_s1_mode <= '0;
            r_s1_clip <= '0;
        end else if (w_in_ready) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= in_mode;
                r_s1_clip <= clip_max;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_W-1:0] w_x;
            logic signed [DATA_W-1:0] w_leak;
            logic signed [DATA_W-1:0] w_y;
            logic                     w_pos;

            assign w_x    = r_s1_data[gi*DATA_W +: DATA_W];
            assign w_leak = w_x >>> LEAK_SHIFT;
            assign w_pos  = !w_x[DATA_W-1] && (|w_x);

            always_comb begin
                w_y = w_x;
                case (r_s1_mode)
                    c_MODE_RELU:  w_y = w_pos ? w_x : '0;
                    c_MODE_LEAKY: w_y = w_pos ? w_x : w_leak;
                    // A non-positive bound forces every lane to zero
                    c_MODE_CLIP: begin
                        if (!w_pos || !w_clip_pos) w_y = '0;
                        else if (w_x > r_s1_clip)  w_y = r_s1_clip;
                        else                       w_y = w_x;
                    end
                    c_MODE_PASS:  w_y = w_x;
                    default:      w_y = w_x;
                endcase
            end

            assign w_result[gi*DATA_W +: DATA_W] = w_y;
            assign w_sign[gi] = w_x[DATA_W-1];
        end
    endgenerate

    always_comb begin
        w_neg = '0;
        for (int i = 0; i < LANES; i++) begin
            w_neg = w_neg + c_NEG_W'(w_sign[i]);
        end
    end

    // Stage 2: result register, holds its beat while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_data <= '0;
            r_s2_neg  <= '0;
        end else if (w_s2_take) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_data <= w_result;
                r_s2_neg  <= w_neg;
            end
        end
    end

    assign w_cnt_sum  = {1'b0, r_cnt} + (CNT_W + 1)'(r_s2_neg);
    assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (stat_clr) begin
            r_cnt <= '0;
        end else if (r_v2 && out_ready) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_v2;
    assign out_data  = r_s2_data;
    assign zero_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_relu_act_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_relu_act_pipe                                                 |
// | Brief   : Scoreboard bench for relu_act_pipe (32-bit and 4-bit counters).  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_relu_act_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [15:0] clip_max = '0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;

    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [63:0] out_data, out_data2;
    logic [31:0] zero_cnt;
    logic [3:0]  zero_cnt2;

    typedef struct {
        logic [63:0] data;
        int          neg;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t    sb[$];
    int      cyc = 0;
    int      n_chk = 0;
    int      n_pass = 0;
    longint  exp_cnt = 0;
    int      exp_cnt2 = 0;

    relu_act_pipe #(.DATA_W(16), .LANES(4), .LEAK_SHIFT(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .clip_max(clip_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stat_clr(stat_clr), .zero_cnt(zero_cnt)
    );

    relu_act_pipe #(.DATA_W(16), .LANES(4), .LEAK_SHIFT(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode), .clip_max(clip_max),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .stat_clr(stat_clr), .zero_cnt(zero_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Monitor: compare presented beats with the scoreboard head, track counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", out_valid, 1'b0);
                end else begin
                    check("out_data", out_data, sb[0].data);
                    if (out_ready) begin
                        if (sb[0].lat) check("latency", 64'(cyc - sb[0].cyc), 64'd2);
                        if (!stat_clr) begin
                            exp_cnt  = exp_cnt + sb[0].neg;
                            exp_cnt2 = (exp_cnt2 + sb[0].neg > 15) ? 15 : exp_cnt2 + sb[0].neg;
                        end
                        void'(sb.pop_front());
                    end
                end
            end
            if (stat_clr) begin
                exp_cnt  = 0;
                exp_cnt2 = 0;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the beat is accepted
    task automatic send(input logic [63:0] d, input logic [1:0] m, input int clip,
                        input logic [63:0] exp, input int neg, input bit lat);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        clip_max = clip[15:0];
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
        end else begin
            e.data = exp; e.neg = neg; e.cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 200);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_cnt(input string nm);
        check({nm, "_cnt32"}, 64'(zero_cnt), 64'(exp_cnt));
        check({nm, "_cnt4"}, 64'(zero_cnt2), 64'(exp_cnt2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // ReLU with latency check
        send(pk(-5, 0, 7, -32768), 2'b00, 0, pk(0, 0, 7, 0), 2, 1'b1);
        drain();
        check_cnt("t1");
        check("t1_spec_cnt", 64'(zero_cnt), 64'd2);

        // Per-beat mode/clip changes back to back
        send(pk(-16, -1, 100, -32768), 2'b01, 0, pk(-2, -1, 100, -4096), 3, 1'b0);
        send(pk(2000, -3, 1536, 1000), 2'b10, 1536, pk(1536, 0, 1536, 1000), 1, 1'b0);
        send(pk(2000, 1, 0, -1), 2'b10, -5, pk(0, 0, 0, 0), 1, 1'b0);
        send(pk(-7, 8, -9, 32767), 2'b11, 0, pk(-7, 8, -9, 32767), 2, 1'b0);
        drain();
        check_cnt("t23");

        // Six beats streaming with a 4-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i % 2 == 0)
                        send(pk(i*10+1, -(i+1), i, 100+i), 2'b11, 0,
                             pk(i*10+1, -(i+1), i, 100+i), 1, 1'b0);
                    else
                        send(pk(i*10+1, -(i+1), i, 100+i), 2'b00, 0,
                             pk(i*10+1, 0, i, 100+i), 1, 1'b0);
                end
            end
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 50);
                check("t4_first_valid", out_valid, 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("t4_in_ready_stall", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_cnt("t4");

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        send(pk(-1, -2, 3, 4), 2'b11, 0, pk(-1, -2, 3, 4), 2, 1'b0);
        send(pk(5, -6, 7, -8), 2'b11, 0, pk(5, -6, 7, -8), 2, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        check("t5_async_cnt", 64'(zero_cnt), 64'd0);
        check("t5_async_data", out_data, 64'd0);
        sb.delete();
        exp_cnt  = 0;
        exp_cnt2 = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(pk(-8, 8, -9, 0), 2'b01, 0, pk(-1, 8, -2, 0), 2, 1'b1);
        drain();
        check_cnt("t5");

        // Saturation and clear priority
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check_cnt("t6_clr_idle");
        for (int i = 0; i < 5; i++)
            send(pk(-1, -2, -3, -4), 2'b00, 0, pk(0, 0, 0, 0), 4, 1'b0);
        drain();
        check_cnt("t6_sat");
        check("t6_sat_spec", 64'(zero_cnt2), 64'd15);
        send(pk(-1, -1, -1, -1), 2'b11, 0, pk(-1, -1, -1, -1), 4, 1'b1);
        @(posedge clk);
        #1;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        drain();
        check_cnt("t6_clr_xfer");
        check("t6_clr_spec", 64'(zero_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
